// File: rtl/jt6295_romfetch.sv
// Byte fetch for the jt6295 ROM port, served from a shared 32-bit SDRAM.
// A single 4-byte line is cached, and its tag includes the bank select.
module jt6295_romfetch #(
  parameter int              AW     = 22,
  parameter logic [AW-1:0]   OFFSET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    bank,
  input  logic [17:0]   addr,
  output logic [7:0]    data,
  output logic          ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [31:0]   sdram_din
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state_reg;
  logic        valid_reg;
  logic [17:0] tag_reg;
  logic [17:0] req_tag_reg;
  logic [31:0] line_reg;

  logic [17:0] cur_tag;
  logic        hit;
  logic        fill;

  assign cur_tag = {bank, addr[17:2]};
  assign hit     = valid_reg && (tag_reg == cur_tag);
  assign ok      = hit;
  assign data    = line_reg[{addr[1:0], 3'b000} +: 8];

  // A strobe that coincides with the ack carries the data as well.
  assign fill = sdram_dst && (((state_reg == REQ) && sdram_ack) || (state_reg == WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      tag_reg     <= '0;
      req_tag_reg <= '0;
      line_reg    <= '0;
      sdram_addr  <= '0;
      sdram_req   <= 1'b0;
    end else begin
      if (fill) begin
        line_reg  <= sdram_din;
        tag_reg   <= req_tag_reg;
        valid_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (!hit) begin
            req_tag_reg <= cur_tag;
            sdram_addr  <= AW'(cur_tag) + OFFSET;
            sdram_req   <= 1'b1;
            state_reg   <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state_reg <= sdram_dst ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (sdram_dst) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_romfetch.sv
// Directed bench for jt6295_romfetch: stimulus queues expected requests and bytes,
// a monitor pops and compares them as the DUT raises sdram_req or ok.
module tb_jt6295_romfetch;

  localparam int            AW  = 22;
  localparam logic [AW-1:0] OFS = 22'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    bank = 2'd0;
  logic [17:0]   addr = 18'd0;
  logic [7:0]    data;
  logic          ok;
  logic [AW-1:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ack = 1'b0;
  logic          sdram_dst = 1'b0;
  logic [31:0]   sdram_din = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  bank;
    logic [17:0] addr;
    logic [7:0]  byte_v;
  } rd_t;

  rd_t           exp_rd[$];
  logic [AW-1:0] exp_req[$];

  always #5 clk = ~clk;

  jt6295_romfetch #(.AW(AW), .OFFSET(OFS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank       (bank),
    .addr       (addr),
    .data       (data),
    .ok         (ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_din  (sdram_din)
  );

  // SDRAM contents as a function of the word tag (word 0 is the plan's pattern)
  function automatic logic [31:0] mem_word(input logic [17:0] t);
    if (t == 18'd0) return 32'h44332211;
    return {~t[7:0], t[7:0] ^ 8'h5a, t[15:8] + 8'h03, t[7:0] + 8'h11};
  endfunction

  function automatic logic [17:0] tag_of(input logic [1:0] b, input logic [17:0] a);
    return {b, a[17:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input logic [1:0] b, input logic [17:0] a);
    rd_t e;
    logic [31:0] w;
    w = mem_word(tag_of(b, a));
    e.bank = b;
    e.addr = a;
    e.byte_v = w[{a[1:0], 3'b000} +: 8];
    exp_rd.push_back(e);
  endtask

  task automatic expect_req(input logic [17:0] t);
    exp_req.push_back(AW'(t) + OFS);
  endtask

  // Play the SDRAM side for one request; ack_dly/dst_dly in clocks, dst_dly=0 means ack+data.
  task automatic serve(input int ack_dly, input int dst_dly, input logic [17:0] t,
                       input logic hit_after, input logic chg, input logic [17:0] chg_addr);
    int n;
    n = 0;
    while (!sdram_req && n < 50) begin
      step();
      n++;
    end
    if (!sdram_req) begin
      check("req_timeout", 32'(sdram_req), 32'd1);
      return;
    end
    for (int i = 1; i < ack_dly; i++) step();
    check("req_held", 32'(sdram_req), 32'd1);
    check("ok_while_req", 32'(ok), 32'd0);
    sdram_ack = 1'b1;
    if (dst_dly == 0) begin
      sdram_dst = 1'b1;
      sdram_din = mem_word(t);
    end
    step();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    check("req_drop", 32'(sdram_req), 32'd0);
    if (chg) addr = chg_addr;
    if (dst_dly > 0) begin
      for (int i = 1; i < dst_dly; i++) step();
      check("ok_before_fill", 32'(ok), 32'd0);
      sdram_dst = 1'b1;
      sdram_din = mem_word(t);
      step();
      sdram_dst = 1'b0;
    end
    check("ok_after_dst", 32'(ok), 32'(hit_after));
  endtask

  // Monitor: compares each new request address and each valid byte against the queues
  initial begin : monitor
    logic prev_req;
    rd_t  e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (sdram_req && !prev_req) begin
          if (exp_req.size() == 0) check("unexpected_req", 32'(sdram_addr), 32'hffffffff);
          else check("req_addr", 32'(sdram_addr), 32'(exp_req.pop_front()));
        end
        prev_req = sdram_req;
        if (ok && exp_rd.size() > 0 && exp_rd[0].addr == addr && exp_rd[0].bank == bank) begin
          e = exp_rd.pop_front();
          check("rd_data", 32'(data), 32'(e.byte_v));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // reset state
    step();
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    step();

    // first miss at bank 0, addr 0
    expect_req(18'd0);
    expect_read(2'd0, 18'd0);
    rst_n = 1'b1;
    serve(2, 3, 18'd0, 1'b1, 1'b0, 18'd0);

    // sequential hits inside the line
    for (int a = 1; a < 4; a++) begin
      step();
      addr = 18'(a);
      expect_read(2'd0, addr);
    end
    step();

    // stray ack/dst while idle and hitting
    sdram_ack = 1'b1;
    sdram_dst = 1'b1;
    sdram_din = 32'hdeadbeef;
    step();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    expect_read(2'd0, 18'd3);
    step();
    check("stray_no_req", 32'(sdram_req), 32'd0);
    check("stray_ok", 32'(ok), 32'd1);

    // bank 3 with offset, then ack+dst in the same cycle
    bank = 2'd3;
    addr = 18'h00004;
    expect_req(tag_of(2'd3, 18'h4));
    expect_read(2'd3, 18'h4);
    serve(1, 2, tag_of(2'd3, 18'h4), 1'b1, 1'b0, 18'd0);
    step();
    addr = 18'h0000a;
    expect_req(tag_of(2'd3, 18'ha));
    expect_read(2'd3, 18'ha);
    serve(1, 0, tag_of(2'd3, 18'ha), 1'b1, 1'b0, 18'd0);
    step();

    // address moves during WAIT: old line fills, then a new request follows
    bank = 2'd0;
    addr = 18'h10;
    expect_req(18'd4);
    expect_req(18'd8);
    expect_read(2'd0, 18'h20);
    serve(2, 2, 18'd4, 1'b0, 1'b1, 18'h20);
    check("idle_after_fill", 32'(sdram_req), 32'd0);
    step();
    check("rereq_1clk", 32'(sdram_req), 32'd1);
    serve(2, 2, 18'd8, 1'b1, 1'b0, 18'd0);
    step();

    // bank toggle replaces the single line
    bank = 2'd1;
    #1 check("bank_miss", 32'(ok), 32'd0);
    expect_req(tag_of(2'd1, 18'h20));
    expect_read(2'd1, 18'h20);
    serve(1, 1, tag_of(2'd1, 18'h20), 1'b1, 1'b0, 18'd0);
    step();
    bank = 2'd0;
    #1 check("bank_back_miss", 32'(ok), 32'd0);
    expect_req(18'd8);
    expect_read(2'd0, 18'h20);
    serve(2, 1, 18'd8, 1'b1, 1'b0, 18'd0);
    step();

    // reset during REQ, abandoned dst, fresh request after release
    addr = 18'h40;
    expect_req(18'h10);
    step();
    step();
    check("req_before_rst", 32'(sdram_req), 32'd1);
    rst_n = 1'b0;
    addr = 18'h20;
    #1;
    check("rst_req_drop", 32'(sdram_req), 32'd0);
    check("rst_ok_clear", 32'(ok), 32'd0);
    check("rst_addr_clear", 32'(sdram_addr), 32'd0);
    step();
    step();
    sdram_dst = 1'b1;
    sdram_din = 32'hcafef00d;
    step();
    sdram_dst = 1'b0;
    check("rst_dst_ignored", 32'(ok), 32'd0);
    step();
    expect_req(18'd8);
    expect_read(2'd0, 18'h20);
    rst_n = 1'b1;
    serve(2, 2, 18'd8, 1'b1, 1'b0, 18'd0);
    step();
    step();

    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
